// File: rtl/isdu_ctrl.sv
// isdu_ctrl: Moore control sequencer for the simplified LC-3 datapath.
// Steps through fetch, decode and execute. Every control strobe, bus gate
// and mux select is decoded from the state register and the memory wait
// counter. The only exception is SR2MUX, which follows IR[5] in the
// ADD/AND states.
module isdu_ctrl #(
    // Cycles each memory read/write state is held (legal range 1..15)
    parameter int MEM_WAIT = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_OE,
    output logic       Mem_WE,
    output logic       Halted
);

    typedef enum logic [4:0] {
        S_HALTED   = 5'd0,
        S_FETCH1   = 5'd1,
        S_FETCH2   = 5'd2,
        S_FETCH3   = 5'd3,
        S_DECODE   = 5'd4,
        S_ADD      = 5'd5,
        S_AND      = 5'd6,
        S_NOT      = 5'd7,
        S_BR       = 5'd8,
        S_BR_TAKEN = 5'd9,
        S_JMP      = 5'd10,
        S_LDR1     = 5'd11,
        S_LDR2     = 5'd12,
        S_LDR3     = 5'd13,
        S_STR1     = 5'd14,
        S_STR2     = 5'd15,
        S_STR3     = 5'd16,
        S_PAUSE1   = 5'd17,
        S_PAUSE2   = 5'd18
    } state_t;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_PAUS = 4'b1101;

    // Final count of a memory state: the state is left when the counter reaches it
    localparam logic [3:0] LAST_CNT = 4'(MEM_WAIT - 1);

    state_t     state_q, state_d;
    logic [3:0] waitCnt_q, waitCnt_d;
    logic       inMem;
    logic       memLast;

    assign inMem   = (state_q == S_FETCH2) || (state_q == S_LDR2) || (state_q == S_STR3);
    assign memLast = (waitCnt_q == LAST_CNT);

    // State and wait-counter registers; reset drops straight to HALTED
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_HALTED;
            waitCnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
        end
    end

    // Wait counter counts up inside a memory state and is zero everywhere else,
    // so it is already cleared on entry to the next memory state
    always_comb begin
        waitCnt_d = 4'd0;
        if (inMem && !memLast) begin
            waitCnt_d = waitCnt_q + 4'd1;
        end
    end

    // Next-state sequencing through fetch, decode and the execute routines
    always_comb begin
        state_d = S_HALTED;
        case (state_q)
            S_HALTED:   state_d = Run ? S_FETCH1 : S_HALTED;
            S_FETCH1:   state_d = S_FETCH2;
            S_FETCH2:   state_d = memLast ? S_FETCH3 : S_FETCH2;
            S_FETCH3:   state_d = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_ADD:  state_d = S_ADD;
                    OP_AND:  state_d = S_AND;
                    OP_NOT:  state_d = S_NOT;
                    OP_BR:   state_d = S_BR;
                    OP_JMP:  state_d = S_JMP;
                    OP_LDR:  state_d = S_LDR1;
                    OP_STR:  state_d = S_STR1;
                    OP_PAUS: state_d = S_PAUSE1;
                    default: state_d = S_FETCH1;
                endcase
            end
            S_ADD:      state_d = S_FETCH1;
            S_AND:      state_d = S_FETCH1;
            S_NOT:      state_d = S_FETCH1;
            S_BR:       state_d = BEN ? S_BR_TAKEN : S_FETCH1;
            S_BR_TAKEN: state_d = S_FETCH1;
            S_JMP:      state_d = S_FETCH1;
            S_LDR1:     state_d = S_LDR2;
            S_LDR2:     state_d = memLast ? S_LDR3 : S_LDR2;
            S_LDR3:     state_d = S_FETCH1;
            S_STR1:     state_d = S_STR2;
            S_STR2:     state_d = S_STR3;
            S_STR3:     state_d = memLast ? S_FETCH1 : S_STR3;
            S_PAUSE1:   state_d = Continue ? S_PAUSE2 : S_PAUSE1;
            S_PAUSE2:   state_d = Continue ? S_PAUSE2 : S_FETCH1;
            default:    state_d = S_HALTED;
        endcase
    end

    // Control word for the current state; anything not named stays low
    always_comb begin
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = 2'b00;
        DRMUX      = 1'b0;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = 2'b00;
        ALUK       = 2'b00;
        Mem_OE     = 1'b0;
        Mem_WE     = 1'b0;
        Halted     = 1'b0;
        case (state_q)
            S_HALTED: Halted = 1'b1;
            S_FETCH1: begin
                GatePC = 1'b1;
                LD_MAR = 1'b1;
                LD_PC  = 1'b1;
                PCMUX  = 2'b00;
            end
            S_FETCH2, S_LDR2: begin
                Mem_OE = 1'b1;
                LD_MDR = memLast;
            end
            S_FETCH3: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
            end
            S_DECODE: LD_BEN = 1'b1;
            S_ADD, S_AND, S_NOT: begin
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                SR1MUX  = 1'b1;
                if (state_q == S_AND) begin
                    ALUK = 2'b01;
                end else if (state_q == S_NOT) begin
                    ALUK = 2'b10;
                end
                SR2MUX = (state_q != S_NOT) ? IR_5 : 1'b0;
            end
            S_BR_TAKEN: begin
                LD_PC    = 1'b1;
                PCMUX    = 2'b10;
                ADDR1MUX = 1'b0;
                ADDR2MUX = 2'b10;
            end
            S_JMP: begin
                LD_PC    = 1'b1;
                PCMUX    = 2'b10;
                ADDR1MUX = 1'b1;
                ADDR2MUX = 2'b00;
            end
            S_LDR1, S_STR1: begin
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
                ADDR1MUX   = 1'b1;
                ADDR2MUX   = 2'b01;
            end
            S_LDR3: begin
                GateMDR = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
            end
            S_STR2: begin
                GateALU = 1'b1;
                ALUK    = 2'b11;
                LD_MDR  = 1'b1;
                SR1MUX  = 1'b0;
            end
            S_STR3: Mem_WE = 1'b1;
            default: ;
        endcase
    end

endmodule
